// File: rtl/rvfi_regfile_monitor.sv
// RVFI register-file consistency monitor.
// Shadows every architectural register and flags bad retirements.
module rvfi_regfile_monitor #(
   parameter int XLEN      = 32,
   parameter int NRET      = 1,
   parameter int NREGS     = 32,
   parameter int ORDER_W   = 8,
   parameter bit ZERO_INIT = 1'b0,
   parameter int CH_W      = (NRET > 1) ? $clog2(NRET) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NRET-1:0]         rvfi_valid,
   input  logic [NRET*ORDER_W-1:0] rvfi_order,
   input  logic [NRET-1:0]         rvfi_trap,
   input  logic [NRET*5-1:0]       rvfi_rs1_addr,
   input  logic [NRET*5-1:0]       rvfi_rs2_addr,
   input  logic [NRET*5-1:0]       rvfi_rd_addr,
   input  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata,
   input  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata,
   input  logic [NRET*XLEN-1:0]    rvfi_rd_wdata,
   output logic                    err_any,
   output logic                    err_sticky,
   output logic [2:0]              err_code,
   output logic [CH_W-1:0]         err_channel,
   output logic [ORDER_W-1:0]      err_order,
   output logic [15:0]             err_count
);

   localparam logic [5:0] NR = 6'(NREGS);
   localparam logic [ORDER_W-1:0] ONE = {{(ORDER_W-1){1'b0}}, 1'b1};

   logic [XLEN-1:0]    shadow_q [NREGS];
   logic [XLEN-1:0]    shadow_d [NREGS];
   logic [NREGS-1:0]   wr_q, wr_d;
   logic [ORDER_W-1:0] exp_q, exp_d;
   logic               known_q, known_d;

   logic [4:0]         rs1, rs2, rd;
   logic [XLEN-1:0]    d1, d2, wd, rv1, rv2;
   logic [ORDER_W-1:0] ord;
   logic               trap, rng, w1, w2;
   logic [2:0]         code;

   int                 nerr;
   logic               first_v;
   logic [2:0]         first_code;
   logic [CH_W-1:0]    first_ch;
   logic [ORDER_W-1:0] first_ord;
   logic [16:0]        cnt_sum;

   // Walk channels in order, forwarding shadow/order updates to later ones.
   always_comb begin
      shadow_d   = shadow_q;
      wr_d       = wr_q;
      exp_d      = exp_q;
      known_d    = known_q;
      nerr       = 0;
      first_v    = 1'b0;
      first_code = '0;
      first_ch   = '0;
      first_ord  = '0;
      rs1 = '0; rs2 = '0; rd = '0;
      d1 = '0; d2 = '0; wd = '0; rv1 = '0; rv2 = '0;
      ord = '0; trap = 1'b0; rng = 1'b0; w1 = 1'b0; w2 = 1'b0;
      code = '0;
      for (int k = 0; k < NRET; k++) begin
         rs1  = rvfi_rs1_addr[k*5 +: 5];
         rs2  = rvfi_rs2_addr[k*5 +: 5];
         rd   = rvfi_rd_addr[k*5 +: 5];
         d1   = rvfi_rs1_rdata[k*XLEN +: XLEN];
         d2   = rvfi_rs2_rdata[k*XLEN +: XLEN];
         wd   = rvfi_rd_wdata[k*XLEN +: XLEN];
         ord  = rvfi_order[k*ORDER_W +: ORDER_W];
         trap = rvfi_trap[k];
         rv1  = '0;
         rv2  = '0;
         w1   = 1'b0;
         w2   = 1'b0;
         for (int j = 1; j < NREGS; j++) begin
            if (rs1 == 5'(j)) begin
               rv1 = shadow_d[j];
               w1  = wr_d[j];
            end
            if (rs2 == 5'(j)) begin
               rv2 = shadow_d[j];
               w2  = wr_d[j];
            end
         end
         rng  = ({1'b0, rs1} >= NR) || ({1'b0, rs2} >= NR)
             || ({1'b0, rd} >= NR);
         code = 3'd0;
         if (rvfi_valid[k]) begin
            if (rng)
               code = 3'd5;
            else if (known_d && ord != exp_d)
               code = 3'd4;
            else if ((rs1 == 5'd0 && d1 != '0) ||
                     (rs2 == 5'd0 && d2 != '0) ||
                     (rd == 5'd0 && wd != '0 && !trap))
               code = 3'd3;
            else if (w1 && d1 != rv1)
               code = 3'd1;
            else if (w2 && d2 != rv2)
               code = 3'd2;
            exp_d   = ord + ONE;
            known_d = 1'b1;
            if (!trap && !rng && rd != 5'd0) begin
               for (int j = 1; j < NREGS; j++) begin
                  if (rd == 5'(j)) begin
                     shadow_d[j] = wd;
                     wr_d[j]     = 1'b1;
                  end
               end
            end
            if (code != 3'd0) begin
               nerr = nerr + 1;
               if (!first_v) begin
                  first_v    = 1'b1;
                  first_code = code;
                  first_ch   = CH_W'(k);
                  first_ord  = ord;
               end
            end
         end
      end
      cnt_sum = {1'b0, err_count} + 17'(nerr);
   end

   // Commit shadow state and registered error reporting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q    <= '{default: '0};
         wr_q        <= {NREGS{ZERO_INIT}};
         exp_q       <= '0;
         known_q     <= 1'b0;
         err_any     <= 1'b0;
         err_sticky  <= 1'b0;
         err_code    <= '0;
         err_channel <= '0;
         err_order   <= '0;
         err_count   <= '0;
      end else begin
         shadow_q <= shadow_d;
         wr_q     <= wr_d;
         exp_q    <= exp_d;
         known_q  <= known_d;
         err_any  <= (nerr != 0);
         if (!err_sticky && first_v) begin
            err_sticky  <= 1'b1;
            err_code    <= first_code;
            err_channel <= first_ch;
            err_order   <= first_ord;
         end
         err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
   end

endmodule

// File: doc/rvfi_regfile_monitor.md
# rvfi_regfile_monitor

Full-register-file consistency monitor for the RVFI retirement trace, with configurable width, retirement channels, register count and order-counter width. Shadows every architectural register and flags any retired instruction whose rs1/rs2 read data disagrees with the last value written to that register. It also flags x0 violations, out-of-range register indices and gaps in the retirement order. It sits beside the core under test in simulation and formal harnesses and reports errors on registered flags instead of asserting directly.

## Interface
- XLEN, 32, register width in bits
- NRET, 1, retirement channels per cycle
- NREGS, 32, architectural registers (16 for RV32E)
- ORDER_W, 8, width of each rvfi_order field
- ZERO_INIT, 0, 1: all shadow registers start written with value 0
- CH_W, max(1,$clog2(NRET)), derived, channel index width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rvfi_valid  in  NRET  per-channel retirement valid
- rvfi_order  in  NRET*ORDER_W  retirement sequence number
- rvfi_trap  in  NRET  instruction trapped
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  NRET*5 each  register indices
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  in  NRET*XLEN each  register data
- err_any  out  1  pulse: at least one channel erred in the sampled cycle
- err_sticky  out  1  set on first error, held until reset
- err_code  out  3  code of first error since reset
- err_channel  out  CH_W  channel of first error
- err_order  out  ORDER_W  rvfi_order of first erroneous retirement
- err_count  out  16  erroneous retirements, saturating at 16'hFFFF

## Operation
- State: shadow[1..NREGS-1] (XLEN each), written[1..NREGS-1], exp_order (ORDER_W), order_known.
- Reset values: shadow=0, written=all ZERO_INIT, order_known=0, exp_order=0. All outputs 0.
- Each edge, valid channels are processed in ascending index. Channel k sees shadow and order updates from channels <k in the same cycle (intra-cycle forwarding).
- Per valid channel, checks in priority order. The highest-priority failing check gives that channel's code.
  - 5 RANGE: rs1, rs2 or rd index >= NREGS.
  - 4 ORDER: order_known and order != exp_order. Compare modulo 2^ORDER_W, so 0xFF→0x00 is legal at ORDER_W=8.
  - 3 X0: rs1_addr==0 with rs1_rdata!=0, rs2_addr==0 with rs2_rdata!=0, or rd_addr==0 with rd_wdata!=0 and trap=0.
  - 1 RS1: rs1 written, and rs1_rdata != shadow[rs1].
  - 2 RS2: same check for rs2.
- Order update, always, including on error: exp_order = order+1 (wraps), order_known=1.
- Shadow update applies only when trap=0, rd in 1..NREGS-1 and the channel passed RANGE. It sets shadow[rd]=rd_wdata and written[rd]=1.
- Writes to one register from several channels in one cycle: the highest channel wins.
- Trapped retirements are still checked on rs1/rs2 and order. rd_wdata is ignored.
- Invalid channels: no checks, no updates, including order.
- First-error capture: if err_sticky=0 and any channel errs, latch code, channel and order of the lowest erring channel, and set err_sticky. Later errors do not overwrite the capture.
- err_count increases by the number of erring channels in the cycle and saturates.

## Timing
- Outputs are registered. A retirement sampled at edge N drives err_any high from N to N+1. err_sticky and the capture fields are valid from N onward.
- err_any is cleared the next edge if no channel errs. There are no back-to-back constraints; every cycle may retire NRET instructions.
- Throughput: NRET retirements per cycle, no stall, no backpressure.
- Reset asserted mid-trace: all state and outputs clear asynchronously. The first retirement after release re-seeds order tracking.
- Registers are never written after reset with ZERO_INIT=0: their read checks stay disabled.

## Test plan
- NRET=1: write x5=0x1234 (order 0), then read rs1=x5 with 0x1234 (order 1) -> no error. Then read 0x1235 (order 2) -> err_any pulse, err_code=1, err_order=2, err_count=1.
- NRET=2, same cycle: ch0 writes x7=0xAA, ch1 reads rs2=x7 with 0xAA -> no error. Repeat with ch1 rdata 0x00 -> err_code=2, err_channel=1.
- Orders 0xFE, 0xFF, 0x00 -> no error. Then 0x02 -> err_code=4, err_order=0x02. Then 0x03 -> no further error, because re-seeded from 0x02.
- Trapped retirement with rd=x3, wdata=0x55, then read x3: x3 unwritten -> no error. With ZERO_INIT=1, reading x3 as 0x55 -> err_code=1.
- NREGS=16: rd_addr=20 -> err_code=5, no shadow update. Read x0 returning 1 -> err_code=3. err_count=2, err_code still 5 (first captured).
- Reset pulse after errors: all outputs 0 immediately. The next retirement with any order and a read of a previously written register -> no error.
